// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit: 34 cycles per op, HI/LO registers, MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the DIV/DIVU datapath; otherwise only MULT/MULTU are accepted.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_m;
    logic [63:0] r_acc;
    logic        r_neg_q;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
`ifdef MULDIV_DIV_EN
    logic        r_op_div;
    logic        r_neg_r;
    logic        r_dz;
`endif

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic        w_accept;
    logic [32:0] w_mul_sum;
    logic [63:0] w_step;
    logic [63:0] w_result;

    // op[0]=0 selects the signed flavour of both multiply and divide
    assign w_a_neg = ~op[0] & dataA[31];
    assign w_b_neg = ~op[0] & dataB[31];
    assign w_a_abs = w_a_neg ? (32'd0 - dataA) : dataA;
    assign w_b_abs = w_b_neg ? (32'd0 - dataB) : dataB;

`ifdef MULDIV_DIV_EN
    assign w_accept = start;
`else
    assign w_accept = start & ~op[1];
`endif

    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);

`ifdef MULDIV_DIV_EN
    logic [64:0] w_div_shift;
    logic [32:0] w_div_diff;
    assign w_div_shift = {r_acc, 1'b0};
    assign w_div_diff  = w_div_shift[64:32] - {1'b0, r_m};

    // r_acc holds {remainder, dividend/quotient} while dividing
    always_comb begin
        w_step = {w_mul_sum, r_acc[31:1]};
        if (r_op_div) begin
            if (!w_div_diff[32])
                w_step = {w_div_diff[31:0], w_div_shift[31:1], 1'b1};
            else
                w_step = w_div_shift[63:0];
        end
    end
`else
    assign w_step = {w_mul_sum, r_acc[31:1]};
`endif

    always_comb begin
        w_result = r_neg_q ? (64'd0 - r_acc) : r_acc;
`ifdef MULDIV_DIV_EN
        if (r_op_div) begin
            w_result[31:0]  = r_dz ? 32'hFFFF_FFFF
                            : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
            w_result[63:32] = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_m      <= 32'd0;
            r_acc    <= 64'd0;
            r_neg_q  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_op_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= 6'd0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_m     <= w_a_abs;
                        r_acc   <= {32'd0, w_b_abs};
`ifdef MULDIV_DIV_EN
                        r_op_div <= op[1];
                        r_neg_r  <= w_a_neg;
                        r_dz     <= (dataB == 32'd0);
                        if (op[1]) begin
                            r_m   <= w_b_abs;
                            r_acc <= {32'd0, w_a_abs};
                        end
`endif
                    end else begin
                        if (hi_we) r_hi <= dataA;
                        if (lo_we) r_lo <= dataA;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_result[63:32];
                    r_lo    <= w_result[31:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: reference-model scoreboard over multiply/divide, MTHI/MTLO and reset cases.
// Divide vectors run only when MULDIV_DIV_EN is defined; otherwise DIV start must be ignored.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 64'd0;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .dataA(dataA), .dataB(dataB), .hi_we(hi_we), .lo_we(lo_we),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        case (m_op)
            2'd0: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic issue(input logic [1:0] i_op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = i_op;
        dataA = a;
        dataB = b;
        exp_q.push_back(model(i_op, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
    endtask

    // Returns at the negedge where done is seen, with the count of busy negedges before it.
    task automatic wait_done(output int cyc, output bit timed_out);
        cyc = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (hi !== 32'd0)  begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'd0)  begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ops();
`ifdef MULDIV_DIV_EN
        localparam int N = 12;
        logic [1:0]  t_op[N] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] t_a[N]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                                 32'hFFFF_FFFB, 32'hDEAD_BEEF, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] t_b[N]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                                 32'd0, 32'd16, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0};
`else
        localparam int N = 6;
        logic [1:0]  t_op[N] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
        logic [31:0] t_a[N]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
        logic [31:0] t_b[N]  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
`endif
        int          cyc;
        bit          to;
        logic [63:0] exp;
        for (int i = 0; i < N; i++) begin
            if (t_a[i] == 32'd0 && t_b[i] == 32'd0) begin
                t_a[i] = $urandom;
                t_b[i] = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            end
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(cyc, to);
            exp = exp_q.pop_front();
            n_vec++;
            if (to) begin
                n_err++; $display("FAIL op%0d_timeout no done within budget op=%0d", i, t_op[i]);
            end else begin
                if ({hi, lo} !== exp) begin
                    n_err++;
                    $display("FAIL op%0d_result op=%0d a=%h b=%h got %h_%h want %h_%h",
                             i, t_op[i], t_a[i], t_b[i], hi, lo, exp[63:32], exp[31:0]);
                end
                n_vec++;
                if (cyc !== 33) begin n_err++; $display("FAIL op%0d_busy_len got %0d want 33", i, cyc); end
                @(negedge clk);
                n_vec++;
                if (done !== 1'b0) begin n_err++; $display("FAIL op%0d_done_pulse got %b want 0", i, done); end
            end
            last_exp = exp;
        end
    endtask

    task automatic test_mt();
        hi_we = 1'b1; dataA = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        n_vec++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi got %h want 00001234", hi); end
        lo_we = 1'b1; dataA = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        n_vec++; if (lo !== 32'h5678) begin n_err++; $display("FAIL mtlo got %h want 00005678", lo); end
        hi_we = 1'b1; lo_we = 1'b1; dataA = 32'hABCD_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_vec++;
        if ({hi, lo} !== {32'hABCD_0001, 32'hABCD_0001}) begin
            n_err++; $display("FAIL mt_both got %h_%h want abcd0001_abcd0001", hi, lo);
        end
        last_exp = {32'hABCD_0001, 32'hABCD_0001};
    endtask

    task automatic test_start_with_write();
        int          cyc;
        bit          to;
        logic [63:0] exp;
        lo_we = 1'b1;
        issue(2'd1, 32'd9, 32'd11);
        lo_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (lo !== last_exp[31:0]) begin n_err++; $display("FAIL start_lo_we_drop got %h want %h", lo, last_exp[31:0]); end
        wait_done(cyc, to);
        exp = exp_q.pop_front();
        n_vec++;
        if (to || {hi, lo} !== exp) begin
            n_err++; $display("FAIL start_lo_we_result got %h_%h want %h_%h timeout=%b", hi, lo, exp[63:32], exp[31:0], to);
        end
        last_exp = exp;
        @(negedge clk);
    endtask

    task automatic test_ignored_while_busy();
        int          cyc;
        bit          to;
        logic [63:0] exp;
        issue(2'd0, 32'hFFFF_FFF0, 32'h0000_1001);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd1; dataA = 32'hDEAD_0000; dataB = 32'd3; lo_we = 1'b1; hi_we = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({hi, lo} !== last_exp) begin
            n_err++; $display("FAIL mt_while_busy got %h_%h want %h_%h", hi, lo, last_exp[63:32], last_exp[31:0]);
        end
        wait_done(cyc, to);
        exp = exp_q.pop_front();
        n_vec++;
        if (to || {hi, lo} !== exp) begin
            n_err++; $display("FAIL busy_start_result got %h_%h want %h_%h timeout=%b", hi, lo, exp[63:32], exp[31:0], to);
        end
        last_exp = exp;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_queued cycle %0d got busy=%b want 0", k, busy); end
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        bit          to;
        logic [63:0] exp;
        issue(2'd1, 32'h0001_0000, 32'h0001_0000);
        wait_done(cyc, to);
        exp = exp_q.pop_front();
        n_vec++;
        if (to || {hi, lo} !== exp) begin
            n_err++; $display("FAIL b2b_first got %h_%h want %h_%h timeout=%b", hi, lo, exp[63:32], exp[31:0], to);
        end
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, to);
        exp = exp_q.pop_front();
        n_vec++;
        if (to || {hi, lo} !== exp || cyc !== 33) begin
            n_err++; $display("FAIL b2b_second got %h_%h busy=%0d want %h_%h busy=33 timeout=%b",
                              hi, lo, cyc, exp[63:32], exp[31:0], to);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(2'd0, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        n_vec++;
        if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL mid_reset_hilo got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

`ifndef MULDIV_DIV_EN
    task automatic test_div_disabled();
        bit seen = 1'b0;
        hi_we = 1'b1; lo_we = 1'b1; dataA = 32'h0BAD_F00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'd2; dataA = 32'd100; dataB = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL div_disabled_busy got activity want none"); end
        n_vec++;
        if ({hi, lo} !== {32'h0BAD_F00D, 32'h0BAD_F00D}) begin
            n_err++; $display("FAIL div_disabled_hilo got %h_%h want 0badf00d_0badf00d", hi, lo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ops();
        test_mt();
        test_start_with_write();
        test_ignored_while_busy();
        test_back_to_back();
`ifndef MULDIV_DIV_EN
        test_div_disabled();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, consuming operands and control from the ID/EX pipeline register. Executes MULT, MULTU, DIV and DIVU over 34 cycles and holds results in architectural HI/LO registers. Also serves MTHI/MTLO writes and MFHI/MFLO reads. Drives `busy` to the hazard logic, which stalls any HI/LO-dependent instruction while an operation is in flight.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  EX-stage instruction is a mul/div; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `dataA`  in  32  rs operand, already forwarded.
- `dataB`  in  32  rt operand, already forwarded.
- `hi_we`  in  1  MTHI: write `dataA` to HI.
- `lo_we`  in  1  MTLO: write `dataA` to LO.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in flight; the hazard unit stalls MFHI/MFLO/MTHI/MTLO/mul/div while high.
- `done`  out  1  one-cycle pulse in the cycle HI/LO take a new result.

## Operation
- FSM states:
  - IDLE: `start`=1 → CALC. Latches op, operand magnitudes (signed ops take the absolute value) and result-sign flags; clears the 6-bit iteration counter.
  - CALC: one radix-2 step per cycle. Multiply: conditional add and shift right over a 64-bit accumulator. Divide: restoring subtract and shift-left. Counter 31 → FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done` → IDLE.
- Results:
  - Multiply: {HI,LO} = 64-bit product; signed ops negate if the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
    - Quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero, both DIV and DIVU: LO = 32'hFFFFFFFF, HI = `dataA` as latched. Full latency still applies.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- `hi_we`/`lo_we` in IDLE with `start`=0: the write lands at that edge. Both may be asserted together, each writing `dataA`.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the write is dropped.
- `start`, `hi_we`, `lo_we` while not in IDLE: ignored.
- `op` and operand values are ignored except at the accepting edge.
- `reset` mid-operation: FSM returns to IDLE immediately. HI, LO and counter go to 0; the operation is lost.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE.
- `start` sampled at edge E0.
- `busy`=1 from after E0 through edge E33.
- CALC iterations occur at E1..E32.
- FIX occupies the cycle after E32. HI/LO update at E33.
- `done`=1 for exactly the cycle following E33.
- A new `start` is accepted at E33 only if the FSM is then in IDLE. Earliest back-to-back acceptance is therefore E34.
- `hi`/`lo` are registered outputs. MFHI/MFLO see a new result in the cycle after E33, with no bypass.
- `busy` is registered, with no combinational path from `start`. The hazard unit holds the issuing instruction's successor using `start`&IDLE in the E0 cycle.

## Configuration
- `MULDIV_DIV_EN` defined: all four ops as above.
- `MULDIV_DIV_EN` undefined:
  - Divide datapath is not compiled.
  - `start` with op 10/11 is ignored: FSM stays IDLE, `busy`/`done` stay 0, HI/LO unchanged.
  - MULT/MULTU are unaffected.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → at E33 HI=32'hFFFFFFFE, LO=32'h00000001; `done` high one cycle; `busy` high 33 cycles.
- MULT −3 × 7 → HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- DIV −7 / 2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 100 / 0 → LO=32'hFFFFFFFF, HI=100.
- DIV 32'h80000000 / 32'hFFFFFFFF → LO=32'h80000000, HI=0.
- MTHI 32'h1234 in IDLE → HI=32'h1234 next cycle.
  - MTLO while busy → LO unchanged.
  - `start`+`lo_we` same edge → write dropped, op runs.
- Assert `reset` at E10 of a MULT → `busy`=0, HI=LO=0 immediately. Second `start` at E5 of an op → ignored, first result intact.
  - Without `MULDIV_DIV_EN`: DIV start → `busy` never rises.
